// File: rtl/i2c_target_responder.sv
// I2C target answering TARGET_ADDR. It serves a coherent snapshot of REG_DATA
// on reads and reports master writes as byte strobes.
// Ports: CLK_1MHZ/RESET (sync, active-high); SCL_IN/SDA_IN (async bus pins);
// SDA_DRIVE_LOW (1 = pull SDA low); REG_DATA (byte i at [8i+7:8i]);
// WR_DATA/WR_PTR/WR_STROBE (write report); BUSY (matched START until STOP).
module i2c_target_responder #(
    parameter logic [6:0] TARGET_ADDR = 7'h2A,
    parameter int         NUM_BYTES   = 10,
    parameter int         PTR_W       = 4
) (
    input  logic                   CLK_1MHZ,
    input  logic                   RESET,
    input  logic                   SCL_IN,
    input  logic                   SDA_IN,
    output logic                   SDA_DRIVE_LOW,
    input  logic [8*NUM_BYTES-1:0] REG_DATA,
    output logic [7:0]             WR_DATA,
    output logic [PTR_W-1:0]       WR_PTR,
    output logic                   WR_STROBE,
    output logic                   BUSY
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_WR_BYTE,
        S_WR_ACK,
        S_RD_BYTE,
        S_RD_ACK
    } state_e;

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_BYTES - 1);

    function automatic logic [7:0] byte_sel(
        input logic [8*NUM_BYTES-1:0] v,
        input logic [PTR_W-1:0]       p
    );
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (p == PTR_W'(i)) begin
                r = v[8*i +: 8];
            end
        end
        return r;
    endfunction

    // Out-of-range pointer values written by the master wrap to 0.
    function automatic logic [PTR_W-1:0] load_ptr(input logic [7:0] b);
        logic [PTR_W-1:0] r;
        if (32'(b) >= NUM_BYTES) begin
            r = '0;
        end else begin
            r = b[PTR_W-1:0];
        end
        return r;
    endfunction

    // [0],[1] synchronise; [2] is the previous synced value for edges.
    logic [2:0] scl_sync_q;
    logic [2:0] sda_sync_q;

    state_e                   state_q, state_d;
    logic [2:0]               bit_cnt_q, bit_cnt_d;
    logic [7:0]               shift_q, shift_d;
    logic                     rw_q, rw_d;
    logic [PTR_W-1:0]         ptr_q, ptr_d;
    logic                     first_q, first_d;
    logic                     phase_q, phase_d;
    logic                     drive_q, drive_d;
    logic                     busy_q, busy_d;
    logic [7:0]               wr_data_q, wr_data_d;
    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic                     strobe_q, strobe_d;
    logic [8*NUM_BYTES-1:0]   shadow_q, shadow_d;

    logic       scl_rise, scl_fall, sda_s;
    logic       start_det, stop_det;
    logic [7:0] rx_byte, load_byte, next_byte;
    logic [PTR_W-1:0] ptr_inc;

    assign sda_s     = sda_sync_q[1];
    assign scl_rise  = scl_sync_q[1] & ~scl_sync_q[2];
    assign scl_fall  = ~scl_sync_q[1] & scl_sync_q[2];
    assign start_det = scl_sync_q[1] & sda_sync_q[2] & ~sda_sync_q[1];
    assign stop_det  = scl_sync_q[1] & ~sda_sync_q[2] & sda_sync_q[1];

    assign rx_byte   = {shift_q[6:0], sda_s};
    assign ptr_inc   = (ptr_q == LAST_PTR) ? '0 : ptr_q + PTR_W'(1);
    assign load_byte = byte_sel(REG_DATA, ptr_q);
    assign next_byte = byte_sel(shadow_q, ptr_inc);

    always_ff @(posedge CLK_1MHZ) begin
        if (RESET) begin
            scl_sync_q <= 3'b111;
            sda_sync_q <= 3'b111;
            state_q    <= S_IDLE;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'h00;
            rw_q       <= 1'b0;
            ptr_q      <= '0;
            first_q    <= 1'b0;
            phase_q    <= 1'b0;
            drive_q    <= 1'b0;
            busy_q     <= 1'b0;
            wr_data_q  <= 8'h00;
            wr_ptr_q   <= '0;
            strobe_q   <= 1'b0;
            shadow_q   <= '0;
        end else begin
            scl_sync_q <= {scl_sync_q[1:0], SCL_IN};
            sda_sync_q <= {sda_sync_q[1:0], SDA_IN};
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            rw_q       <= rw_d;
            ptr_q      <= ptr_d;
            first_q    <= first_d;
            phase_q    <= phase_d;
            drive_q    <= drive_d;
            busy_q     <= busy_d;
            wr_data_q  <= wr_data_d;
            wr_ptr_q   <= wr_ptr_d;
            strobe_q   <= strobe_d;
            shadow_q   <= shadow_d;
        end
    end

    // phase_q in the ACK states: 0 = waiting for the fall that starts the
    // ACK slot, 1 = inside the slot (or next read byte already loaded).
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        rw_d      = rw_q;
        ptr_d     = ptr_q;
        first_d   = first_q;
        phase_d   = phase_q;
        drive_d   = drive_q;
        busy_d    = busy_q;
        wr_data_d = wr_data_q;
        wr_ptr_d  = wr_ptr_q;
        strobe_d  = 1'b0;
        shadow_d  = shadow_q;

        if (stop_det) begin
            state_d = S_IDLE;
            drive_d = 1'b0;
            busy_d  = 1'b0;
        end else if (start_det) begin
            state_d   = S_ADDR;
            bit_cnt_d = 3'd0;
            drive_d   = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                end
                S_ADDR: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (rx_byte[7:1] == TARGET_ADDR) begin
                                state_d = S_ADDR_ACK;
                                busy_d  = 1'b1;
                                rw_d    = rx_byte[0];
                                phase_d = 1'b0;
                            end else begin
                                state_d = S_IDLE;
                            end
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!phase_q) begin
                            drive_d = 1'b1;
                            phase_d = 1'b1;
                        end else if (!rw_q) begin
                            drive_d   = 1'b0;
                            state_d   = S_WR_BYTE;
                            bit_cnt_d = 3'd0;
                            first_d   = 1'b1;
                        end else begin
                            shadow_d  = REG_DATA;
                            shift_d   = load_byte;
                            drive_d   = ~load_byte[7];
                            bit_cnt_d = 3'd0;
                            state_d   = S_RD_BYTE;
                        end
                    end
                end
                S_WR_BYTE: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = S_WR_ACK;
                            phase_d = 1'b0;
                            first_d = 1'b0;
                            if (first_q) begin
                                ptr_d = load_ptr(rx_byte);
                            end else begin
                                wr_data_d = rx_byte;
                                wr_ptr_d  = ptr_q;
                                strobe_d  = 1'b1;
                                ptr_d     = ptr_inc;
                            end
                        end
                    end
                end
                S_WR_ACK: begin
                    if (scl_fall) begin
                        if (!phase_q) begin
                            drive_d = 1'b1;
                            phase_d = 1'b1;
                        end else begin
                            drive_d   = 1'b0;
                            state_d   = S_WR_BYTE;
                            bit_cnt_d = 3'd0;
                        end
                    end
                end
                S_RD_BYTE: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 3'd7) begin
                            drive_d = 1'b0;
                            state_d = S_RD_ACK;
                            phase_d = 1'b0;
                        end else begin
                            shift_d   = {shift_q[6:0], 1'b0};
                            drive_d   = ~shift_q[6];
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
                S_RD_ACK: begin
                    if (scl_rise && !phase_q) begin
                        if (!sda_s) begin
                            ptr_d   = ptr_inc;
                            shift_d = next_byte;
                            phase_d = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                            drive_d = 1'b0;
                        end
                    end else if (scl_fall && phase_q) begin
                        drive_d   = ~shift_q[7];
                        bit_cnt_d = 3'd0;
                        state_d   = S_RD_BYTE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    drive_d = 1'b0;
                end
            endcase
        end
    end

    assign SDA_DRIVE_LOW = drive_q;
    assign WR_DATA       = wr_data_q;
    assign WR_PTR        = wr_ptr_q;
    assign WR_STROBE     = strobe_q;
    assign BUSY          = busy_q;

endmodule

// File: tb/tb_i2c_target_responder.sv
// Bench for i2c_target_responder: bus-level master, transaction model,
// and a scoreboard matching ACKs, read bytes and write strobes.
`timescale 1ns/1ps
module tb_i2c_target_responder;

    localparam int NB = 10;
    localparam int PW = 4;
    localparam int Q  = 5;
    localparam logic [7:0] AW = {7'h2A, 1'b0};
    localparam logic [7:0] AR = {7'h2A, 1'b1};
    localparam int K_ACK = 0;
    localparam int K_RD  = 1;
    localparam int K_STB = 2;

    typedef struct {
        int kind;
        int val;
    } item_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            scl;
    logic            m_sda;
    logic            sda_bus;
    logic            drv;
    logic [8*NB-1:0] reg_data;
    logic [7:0]      wr_data;
    logic [PW-1:0]   wr_ptr;
    logic            wr_stb;
    logic            busy;

    item_t exp_q[$];
    item_t obs_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    ptr_m   = 0;
    bit    busy_m  = 1'b0;
    bit    mm_win  = 1'b0;
    int    mm_viol = 0;
    logic  drv_prev = 1'b0;

    assign sda_bus = m_sda & ~drv;

    always #500 clk = ~clk;

    i2c_target_responder #(
        .TARGET_ADDR(7'h2A),
        .NUM_BYTES  (NB),
        .PTR_W      (PW)
    ) dut (
        .CLK_1MHZ     (clk),
        .RESET        (rst),
        .SCL_IN       (scl),
        .SDA_IN       (sda_bus),
        .SDA_DRIVE_LOW(drv),
        .REG_DATA     (reg_data),
        .WR_DATA      (wr_data),
        .WR_PTR       (wr_ptr),
        .WR_STROBE    (wr_stb),
        .BUSY         (busy)
    );

    function automatic string kname(input int k);
        if (k == K_ACK) return "ack";
        if (k == K_RD) return "rd_byte";
        return "wr_strobe";
    endfunction

    task automatic check(input string nm, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s got=%0h want=%0h", nm, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (wr_stb) obs_q.push_back('{K_STB, int'({wr_ptr, wr_data})});
        if (mm_win && (drv || busy || wr_stb)) mm_viol++;
        if (drv != drv_prev) begin
            n_tests++;
            if (scl) begin
                n_fail++;
                $display("FAIL sda_change_scl_high got=%0b want=%0b",
                         drv, drv_prev);
            end
        end
        drv_prev = drv;
    end

    always @(negedge clk) begin
        item_t o;
        item_t e;
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_%s got=%0h want=none",
                         kname(o.kind), o.val);
            end else begin
                e = exp_q.pop_front();
                if (e.kind != o.kind || e.val != o.val) begin
                    n_fail++;
                    $display("FAIL sb_%s got=%s:%0h want=%s:%0h",
                             kname(e.kind), kname(o.kind), o.val,
                             kname(e.kind), e.val);
                end
            end
        end
    end

    function automatic logic [8*NB-1:0] rand_bank();
        logic [8*NB-1:0] v;
        for (int i = 0; i < NB; i++) v[8*i +: 8] = 8'($urandom_range(0, 255));
        return v;
    endfunction

    task automatic qwait();
        repeat (Q) @(negedge clk);
    endtask

    task automatic m_bit(input logic b, output logic r);
        m_sda = b;
        qwait();
        scl = 1'b1;
        qwait();
        r = sda_bus;
        qwait();
        scl = 1'b0;
        qwait();
    endtask

    task automatic m_start();
        m_sda = 1'b1;
        qwait();
        scl = 1'b1;
        qwait();
        m_sda = 1'b0;
        qwait();
        scl = 1'b0;
        qwait();
    endtask

    // BUSY must still be high 2 cycles after SDA rises and low after 3.
    task automatic m_stop();
        m_sda = 1'b0;
        qwait();
        scl = 1'b1;
        qwait();
        m_sda = 1'b1;
        repeat (2) @(negedge clk);
        check("busy_before_stop", int'(busy), int'(busy_m));
        @(negedge clk);
        check("busy_after_stop", int'(busy), 0);
        busy_m = 1'b0;
        qwait();
    endtask

    task automatic tx(input logic [7:0] b, input logic want_ack);
        logic r;
        exp_q.push_back('{K_ACK, int'(want_ack)});
        for (int i = 7; i >= 0; i--) m_bit(b[i], r);
        m_bit(1'b1, r);
        obs_q.push_back('{K_ACK, int'(r)});
    endtask

    task automatic rx(input logic nack, input logic [7:0] want);
        logic [7:0] d;
        logic       r;
        exp_q.push_back('{K_RD, int'(want)});
        for (int i = 7; i >= 0; i--) begin
            m_bit(1'b1, r);
            d[i] = r;
        end
        m_bit(nack, r);
        obs_q.push_back('{K_RD, int'(d)});
    endtask

    task automatic wr_data_byte(input logic [7:0] d);
        exp_q.push_back('{K_STB, ptr_m * 256 + int'(d)});
        tx(d, 1'b0);
        ptr_m = (ptr_m + 1) % NB;
    endtask

    task automatic wr_body(input int p, input int n);
        m_start();
        tx(AW, 1'b0);
        busy_m = 1'b1;
        tx(8'(p), 1'b0);
        ptr_m = (p < NB) ? p : 0;
        for (int i = 0; i < n; i++) wr_data_byte(8'($urandom_range(0, 255)));
    endtask

    task automatic rd_body(input int n, input bit mutate);
        logic [8*NB-1:0] snap;
        m_start();
        tx(AR, 1'b0);
        busy_m = 1'b1;
        snap = reg_data;
        for (int i = 0; i < n; i++) begin
            rx(i == n - 1, snap[ptr_m*8 +: 8]);
            if (i != n - 1) ptr_m = (ptr_m + 1) % NB;
            if (mutate) reg_data = rand_bank();
        end
    endtask

    initial begin
        #90_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8*NB-1:0] snap;
        logic [3:0]      nib;
        logic            r;
        int              op;
        rst      = 1'b1;
        scl      = 1'b1;
        m_sda    = 1'b1;
        reg_data = rand_bank();
        repeat (3) @(negedge clk);
        check("rst_sda_drive", int'(drv), 0);
        check("rst_wr_data", int'(wr_data), 0);
        check("rst_wr_ptr", int'(wr_ptr), 0);
        check("rst_wr_strobe", int'(wr_stb), 0);
        check("rst_busy", int'(busy), 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Write pointer 0, repeated START, read two bytes.
        reg_data[7:0]  = 8'hA5;
        reg_data[15:8] = 8'h3C;
        wr_body(0, 0);
        rd_body(2, 1'b0);
        m_stop();

        // Two write strobes from pointer 3.
        m_start();
        tx(AW, 1'b0);
        busy_m = 1'b1;
        tx(8'h03, 1'b0);
        ptr_m = 3;
        wr_data_byte(8'h11);
        wr_data_byte(8'h22);
        m_stop();

        // Foreign address: never driven, never busy, no strobes.
        mm_viol = 0;
        m_start();
        mm_win = 1'b1;
        tx(8'h56, 1'b1);
        tx(8'h99, 1'b1);
        m_stop();
        mm_win = 1'b0;
        check("mismatch_quiet", mm_viol, 0);

        // Pointer wrap 9 -> 0 -> 1 with the bank changing mid-read.
        wr_body(9, 0);
        m_stop();
        rd_body(3, 1'b1);
        m_stop();

        // Reset while the target drives a 0 data bit.
        wr_body(5, 0);
        m_stop();
        reg_data[47:40] = 8'h12;
        m_start();
        tx(AR, 1'b0);
        busy_m = 1'b1;
        check("drive_before_rst", int'(drv), 1);
        rst = 1'b1;
        @(negedge clk);
        check("drive_after_rst", int'(drv), 0);
        check("busy_after_rst", int'(busy), 0);
        check("wr_ptr_after_rst", int'(wr_ptr), 0);
        rst    = 1'b0;
        ptr_m  = 0;
        busy_m = 1'b0;
        m_stop();
        rd_body(1, 1'b0);
        m_stop();

        // Repeated START after 4 bits of a read byte.
        wr_body(2, 0);
        m_stop();
        reg_data[23:16] = 8'($urandom_range(0, 255)) | 8'h08;
        m_start();
        tx(AR, 1'b0);
        busy_m = 1'b1;
        snap = reg_data;
        exp_q.push_back('{K_RD, int'(snap[23:20])});
        for (int i = 3; i >= 0; i--) begin
            m_bit(1'b1, r);
            nib[i] = r;
        end
        obs_q.push_back('{K_RD, int'(nib)});
        m_sda = 1'b1;
        qwait();
        scl = 1'b1;
        qwait();
        check("rstart_released", int'(drv), 0);
        m_sda = 1'b0;
        qwait();
        scl = 1'b0;
        qwait();
        tx(AR, 1'b0);
        rx(1'b1, snap[23:16]);
        m_stop();

        for (int it = 0; it < 20; it++) begin
            op = $urandom_range(0, 2);
            if (op == 0) begin
                wr_body($urandom_range(0, NB - 1), $urandom_range(0, 3));
                m_stop();
            end else if (op == 1) begin
                rd_body($urandom_range(1, 4), 1'($urandom_range(0, 1)));
                m_stop();
            end else begin
                wr_body($urandom_range(0, NB - 1), 0);
                rd_body($urandom_range(1, 4), 1'b0);
                m_stop();
            end
            if ($urandom_range(0, 1) == 1) reg_data = rand_bank();
        end

        repeat (10) @(negedge clk);
        check("exp_drained", exp_q.size(), 0);
        check("obs_drained", obs_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_target_responder.md
Name: i2c_target_responder

Overview:
- I2C target (slave) model of the Geiger-stack sensor: answers transactions issued by the I2C master at the other end of the SCL/SDA bus.
- Oversamples SCL/SDA on the 1 MHz system clock, so the 100 kHz-derived bus is sampled 10x or more per bit.
- Serves a snapshot of a parallel register bank on reads and reports master writes as byte strobes.
- Sits in the test harness, connected to the same SCL/SDA wires the master drives, with open-drain SDA resolved at top level.

Parameters:
- TARGET_ADDR, 7'h2A, 7-bit bus address this block answers to.
- NUM_BYTES, 10, number of readable register bytes (10 bytes = 80 bits).
- PTR_W, 4, register pointer width; must satisfy 2**PTR_W >= NUM_BYTES.

Ports:
- CLK_1MHZ  in  1  system clock; all logic is on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- SCL_IN  in  1  bus SCL, asynchronous to CLK_1MHZ.
- SDA_IN  in  1  bus SDA as read back from the pad, asynchronous.
- SDA_DRIVE_LOW  out  1  1 = pull SDA low; 0 = release (high-Z). Top level forms the tristate.
- REG_DATA  in  8*NUM_BYTES  register bank; byte i = REG_DATA[8i+7:8i].
- WR_DATA  out  8  last byte written by the master.
- WR_PTR  out  PTR_W  register index WR_DATA applies to.
- WR_STROBE  out  1  one-cycle pulse when WR_DATA/WR_PTR are valid.
- BUSY  out  1  high from an address-matched START until STOP.

Behaviour:
- Input sync: SCL_IN and SDA_IN each pass through 2 flops, then a third flop for edge detection. Edges are therefore seen 3 cycles after the pin changes.
- START: synced SDA falls while synced SCL is high. STOP: synced SDA rises while synced SCL is high.
- START/STOP take effect from any state, including mid-byte. A repeated START goes to ADDR and keeps the pointer.
- Data bits are sampled on the detected SCL rise. SDA_DRIVE_LOW changes only on the detected SCL fall, never while SCL is high.
- FSM states: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK.
- IDLE: SDA released. START -> ADDR with the bit counter cleared.
- ADDR: shift in 8 bits, MSB first (7 address bits, then R/W).
  - After the 8th rise: if the address equals TARGET_ADDR -> ADDR_ACK and BUSY=1; otherwise -> IDLE, never drive SDA, ignore everything until the next START.
- ADDR_ACK: on the next SCL fall, drive SDA low. On the following fall:
  - R/W=0: release SDA -> WR_BYTE.
  - R/W=1: copy REG_DATA into the shadow register (reads are coherent for the whole transaction), load byte[ptr] into the shift register, drive its MSB -> RD_BYTE.
- WR_BYTE: shift in 8 bits, then -> WR_ACK.
  - First data byte after the address: load the pointer. Values >= NUM_BYTES are taken modulo via wrap to 0. No strobe.
  - Later bytes: WR_DATA=byte, WR_PTR=ptr, WR_STROBE pulses 1 cycle after the 8th rise, then ptr increments.
- WR_ACK: drive SDA low on the next fall, release on the following fall -> WR_BYTE. Writes are always ACKed.
- RD_BYTE: shift out MSB first, with each new bit presented on the SCL fall. Drive low for 0, release for 1. After the 8th bit's fall, release SDA -> RD_ACK.
- RD_ACK: sample SDA on the SCL rise.
  - 0 (ACK): ptr increments and wraps from NUM_BYTES-1 to 0. The next shadow byte's MSB is driven on the next fall -> RD_BYTE.
  - 1 (NACK): -> IDLE with SDA released. BUSY stays 1 until STOP.
- Pointer: resets to 0 and persists across transactions. It is not reset by STOP.
- Reset values: SDA_DRIVE_LOW=0, WR_DATA=0, WR_PTR=0, WR_STROBE=0, BUSY=0, ptr=0, state IDLE, sync flops all 1 (bus idle).
- RESET asserted mid-transaction: SDA is released on the cycle after RESET is sampled. The block waits for a fresh START, so an in-flight STOP is not required.
- A STOP detected while the block drives SDA low is impossible by construction, because SDA changes only on SCL fall. If a glitch causes one anyway, release SDA and go to IDLE.

Test Plan:
- Write then read: REG_DATA byte0=0xA5, byte1=0x3C. Master sends START, 0x54 (TARGET_ADDR<<1|0), 0x00, repeated START, 0x55, reads 2 bytes with ACK then NACK, STOP. Required: ACK on all 3 address/pointer slots; SDA shows 0xA5 then 0x3C; BUSY falls 3 cycles after STOP.
- Write strobes: START, 0x54, 0x03, 0x11, 0x22, STOP. Required: exactly two WR_STROBE pulses, (ptr=3, data=0x11) then (ptr=4, data=0x22).
- Address mismatch: START, 0x56. Required: SDA_DRIVE_LOW stays 0 through the whole transaction; BUSY stays 0; no strobes.
- Pointer wrap: pointer=9, read 3 bytes with ACK, ACK, NACK. Required: bytes 9, 0, 1 returned; REG_DATA changed mid-read does not alter returned bytes.
- Reset mid-read: assert RESET while the target drives a 0 data bit. Required: SDA_DRIVE_LOW=0 next cycle; ptr=0; a subsequent full read returns byte0.
- Repeated START inside RD_BYTE at bit 4: required return to ADDR, correct ACK of the new address, and no SDA drive during the START condition.
